// File: rtl/pc_branch_ctrl.sv
// Fetch-side program counter with branch-condition evaluation, B/BR target selection,
// HLT freeze state and a retired-instruction counter.
module pc_branch_ctrl #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             is_b,
    input  logic             is_br,
    input  logic             is_hlt,
    input  logic [2:0]       cond,
    input  logic [2:0]       flags,
    input  logic [8:0]       imm9,
    input  logic [WIDTH-1:0] reg_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus2,
    output logic             taken,
    output logic             halted,
    output logic [15:0]      inst_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             flag_z, flag_v, flag_n;
    logic             cond_true;
    logic [WIDTH-1:0] b_offset;
    logic [WIDTH-1:0] b_target;

    assign flag_z = flags[2];
    assign flag_v = flags[1];
    assign flag_n = flags[0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            3'b000: cond_true = ~flag_z;
            3'b001: cond_true = flag_z;
            3'b010: cond_true = ~flag_z & ~flag_n;
            3'b011: cond_true = flag_n;
            3'b100: cond_true = flag_z | ~flag_n;
            3'b101: cond_true = flag_z | flag_n;
            3'b110: cond_true = flag_v;
            3'b111: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Word offset: sign-extend imm9 and scale by two bytes.
    assign b_offset = {{(WIDTH - 10){imm9[8]}}, imm9, 1'b0};
    assign pc_plus2 = pc_q + WIDTH'(2);
    assign b_target = pc_plus2 + b_offset;

    assign taken = (is_b | is_br) & cond_true & (state_q == RUN) & ~is_hlt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (state_q == RUN && !stall) begin
            cnt_d = cnt_q + 16'd1;
            if (is_hlt) begin
                state_d = HALTED;
            end else if (taken) begin
                pc_d = is_br ? reg_target : b_target;
            end else begin
                pc_d = pc_plus2;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_out     = pc_q;
    assign halted     = (state_q == HALTED);
    assign inst_count = cnt_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Scoreboard bench for pc_branch_ctrl: driver predicts each cycle's outputs from a
// behavioural model and queues them; a negedge monitor pops and compares.
module tb_pc_branch_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             is_b;
    logic             is_br;
    logic             is_hlt;
    logic [2:0]       cond;
    logic [2:0]       flags;
    logic [8:0]       imm9;
    logic [WIDTH-1:0] reg_target;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus2;
    logic             taken;
    logic             halted;
    logic [15:0]      inst_count;

    pc_branch_ctrl #(.WIDTH(WIDTH), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .is_b       (is_b),
        .is_br      (is_br),
        .is_hlt     (is_hlt),
        .cond       (cond),
        .flags      (flags),
        .imm9       (imm9),
        .reg_target (reg_target),
        .pc_out     (pc_out),
        .pc_plus2   (pc_plus2),
        .taken      (taken),
        .halted     (halted),
        .inst_count (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] pc2;
        logic        taken;
        logic        halted;
        logic [15:0] count;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic        m_halted;
    logic [15:0] m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_halted = 1'b0;
        m_count  = 16'h0000;
    endtask

    // Apply one cycle of inputs (called just after a rising edge), queue expectations,
    // then advance the model across the coming edge.
    task automatic drive(input logic s, input logic b, input logic br, input logic h,
                         input logic [2:0] c, input logic [2:0] f,
                         input logic [8:0] imm, input logic [15:0] rt);
        exp_t e;
        int   off;
        stall      = s;
        is_b       = b;
        is_br      = br;
        is_hlt     = h;
        cond       = c;
        flags      = f;
        imm9       = imm;
        reg_target = rt;
        e.pc     = m_pc;
        e.pc2    = m_pc + 16'd2;
        e.taken  = (b || br) && cond_ok(c, f) && !m_halted && !h;
        e.halted = m_halted;
        e.count  = m_count;
        sb_q.push_back(e);
        if (!m_halted && !s) begin
            m_count = m_count + 16'd1;
            if (h) begin
                m_halted = 1'b1;
            end else if (e.taken) begin
                if (br) begin
                    m_pc = rt;
                end else begin
                    off  = $signed(imm) * 2;
                    m_pc = m_pc + 16'd2 + 16'(off);
                end
            end else begin
                m_pc = m_pc + 16'd2;
            end
        end
    endtask

    task automatic cycle(input logic s, input logic b, input logic br, input logic h,
                         input logic [2:0] c, input logic [2:0] f,
                         input logic [8:0] imm, input logic [15:0] rt);
        @(posedge clk);
        #1;
        drive(s, b, br, h, c, f, imm, rt);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'd0, 16'h0000);
    endtask

    task automatic jump(input logic [15:0] target);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 3'd0, 9'd0, target);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("pc_out",     {16'd0, pc_out},     {16'd0, mon_e.pc});
            check("pc_plus2",   {16'd0, pc_plus2},   {16'd0, mon_e.pc2});
            check("taken",      {31'd0, taken},      {31'd0, mon_e.taken});
            check("halted",     {31'd0, halted},     {31'd0, mon_e.halted});
            check("inst_count", {16'd0, inst_count}, {16'd0, mon_e.count});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        stall      = 1'b0;
        is_b       = 1'b0;
        is_br      = 1'b0;
        is_hlt     = 1'b0;
        cond       = 3'd0;
        flags      = 3'd0;
        imm9       = 9'd0;
        reg_target = 16'h0000;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("reset_pc",      {16'd0, pc_out},     32'h0000);
        check("reset_halted",  {31'd0, halted},     32'd0);
        check("reset_count",   {16'd0, inst_count}, 32'd0);

        // Release reset and fetch sequentially
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'd0, 16'h0000);
        idle();
        idle();
        idle();

        // Taken B EQ with imm9 = -3, then not-taken with Z clear
        jump(16'h0010);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'b100, 9'h1FD, 16'h0000);
        idle();
        jump(16'h0010);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'b000, 9'h1FD, 16'h0000);
        idle();

        // BR and address wrap
        jump(16'h1234);
        idle();
        jump(16'hFFFE);
        idle();
        idle();

        // Full condition/flag sweep with random offsets and occasional stalls
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                cycle(1'($urandom_range(0, 3) == 0), 1'b1, 1'b0, 1'b0, 3'(c), 3'(f),
                      9'($urandom), 16'($urandom));
            end
        end

        // Random traffic, including the illegal is_b & is_br combination
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), 1'b0,
                  3'($urandom), 3'($urandom), 9'($urandom), 16'($urandom));
        end

        // Explicit two-cycle stall
        jump(16'h0100);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 3'd0, 9'd0, 16'h5555);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'd0, 16'h0000);
        idle();

        // HLT with a simultaneous unconditional B; everything afterwards is ignored
        jump(16'h0040);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 3'd0, 9'h010, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 3'd7,
                  3'($urandom), 9'($urandom), 16'($urandom));
        end

        // Asynchronous reset mid-cycle while halted
        @(posedge clk);
        #1;
        stall = 1'b0;
        is_b  = 1'b0;
        is_br = 1'b0;
        is_hlt = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("halt_reset_pc",     {16'd0, pc_out},     32'h0000);
        check("halt_reset_halted", {31'd0, halted},     32'd0);
        check("halt_reset_count",  {16'd0, inst_count}, 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'd0, 16'h0000);
        idle();
        idle();

        repeat (2) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
